// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports, allocate, and clear handshake.
// Decode/writeback side drives through master; the register file sits on slave.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 2
);
   localparam int IDX_W = $clog2(NREGS);

   logic [NRD*IDX_W-1:0]  rd_idx;
   logic [NRD*DATA_W-1:0] rd_data;
   logic [NRD-1:0]        rd_busy;
   logic [NWR-1:0]        wr_en;
   logic [NWR*IDX_W-1:0]  wr_idx;
   logic [NWR*DATA_W-1:0] wr_data;
   logic                  alloc_en;
   logic [IDX_W-1:0]      alloc_idx;
   logic                  clr_req;
   logic                  clr_busy;
   logic                  clr_done;

   modport master (
      output rd_idx, wr_en, wr_idx, wr_data, alloc_en, alloc_idx, clr_req,
      input  rd_data, rd_busy, clr_busy, clr_done
   );

   modport slave (
      input  rd_idx, wr_en, wr_idx, wr_data, alloc_en, alloc_idx, clr_req,
      output rd_data, rd_busy, clr_busy, clr_done
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard and sequential clear sweep.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 2
) (
   input  logic           clk,
   input  logic           rst,
   regfile_mp_if.slave    bus
);
   localparam int IDX_W = $clog2(NREGS);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t             r_state, w_state_next;
   logic [IDX_W-1:0]   r_cnt, w_cnt_next;
   logic               r_done, w_done_next;
   logic [DATA_W-1:0]  r_regs [NREGS];
   logic [NREGS-1:0]   r_busy;
   logic               w_sweep;
   logic               w_clr_start;

   assign w_sweep     = (r_state == SWEEP);
   assign w_clr_start = (r_state == IDLE) && bus.clr_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_done  <= w_done_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_done_next  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.clr_req) begin
               w_state_next = SWEEP;
               w_cnt_next   = IDX_W'(1);
            end
         end
         SWEEP: begin
            // Register 0 never needs clearing, so the sweep covers 1..NREGS-1.
            if (r_cnt == IDX_W'(NREGS - 1)) begin
               w_state_next = IDLE;
               w_cnt_next   = '0;
               w_done_next  = 1'b1;
            end else begin
               w_cnt_next   = r_cnt + IDX_W'(1);
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign bus.clr_busy = w_sweep;
   assign bus.clr_done = r_done;

   // Ascending port loop: the last non-blocking write wins, so the highest port takes a conflict.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_sweep) begin
         r_regs[r_cnt] <= '0;
      end else begin
         for (int w = 0; w < NWR; w++) begin
            if (bus.wr_en[w] && (bus.wr_idx[w*IDX_W +: IDX_W] != '0)) begin
               r_regs[bus.wr_idx[w*IDX_W +: IDX_W]] <= bus.wr_data[w*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Allocation is applied after the write clears so a same-cycle alloc leaves the bit set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= '0;
      end else if (w_clr_start) begin
         r_busy <= '0;
      end else if (!w_sweep) begin
         for (int w = 0; w < NWR; w++) begin
            if (bus.wr_en[w] && (bus.wr_idx[w*IDX_W +: IDX_W] != '0)) begin
               r_busy[bus.wr_idx[w*IDX_W +: IDX_W]] <= 1'b0;
            end
         end
         if (bus.alloc_en && (bus.alloc_idx != '0)) begin
            r_busy[bus.alloc_idx] <= 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [IDX_W-1:0]  w_idx;
         logic [DATA_W-1:0] w_data;

         assign w_idx = bus.rd_idx[gi*IDX_W +: IDX_W];

         always_comb begin
            w_data = r_regs[w_idx];
`ifdef REGFILE_BYPASS_EN
            if (!w_sweep) begin
               for (int w = 0; w < NWR; w++) begin
                  if (bus.wr_en[w] && (bus.wr_idx[w*IDX_W +: IDX_W] == w_idx)) begin
                     w_data = bus.wr_data[w*DATA_W +: DATA_W];
                  end
               end
            end
`endif
            if (w_idx == '0) begin
               w_data = '0;
            end
         end

         assign bus.rd_data[gi*DATA_W +: DATA_W] = w_data;
         assign bus.rd_busy[gi] = (w_idx != '0) && r_busy[w_idx];
      end
   endgenerate
endmodule
